// File: rtl/sync_fork.sv
// Clocked 4-phase handshake fork: one request channel broadcast to two branches, acked upstream once both complete.
// Optional SYNC_FORK_TIMEOUT_EN adds a sticky diagnostic err flag for overlong waits in REQ/REL.
module sync_fork #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             r0,
    output logic             a0,
    output logic             r1,
    input  logic             a1,
    output logic             r2,
    input  logic             a2,
    output logic             busy,
    output logic [CNT_W-1:0] txn_cnt,
    output logic             err
);

    if (SYNC_STAGES < 2 || TIMEOUT_CYC < 1) begin : g_illegal_params
        $error("sync_fork: SYNC_STAGES must be >= 2 and TIMEOUT_CYC >= 1");
    end

    typedef enum logic [1:0] {IDLE, REQ, ACK, REL} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] r0_sync, a1_sync, a2_sync;
    logic                   r0_s, a1_s, a2_s;
    logic                   leave;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r0_sync <= '0;
            a1_sync <= '0;
            a2_sync <= '0;
        end else begin
            r0_sync <= {r0_sync[SYNC_STAGES-2:0], r0};
            a1_sync <= {a1_sync[SYNC_STAGES-2:0], a1};
            a2_sync <= {a2_sync[SYNC_STAGES-2:0], a2};
        end
    end

    assign r0_s = r0_sync[SYNC_STAGES-1];
    assign a1_s = a1_sync[SYNC_STAGES-1];
    assign a2_s = a2_sync[SYNC_STAGES-1];

    // Exit condition of the current state; shared by the FSM and the wait counter.
    always_comb begin
        leave = 1'b0;
        case (state)
            IDLE:    leave = r0_s;
            REQ:     leave = a1_s & a2_s;
            ACK:     leave = ~r0_s;
            REL:     leave = ~a1_s & ~a2_s;
            default: leave = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= IDLE;
            a0      <= 1'b0;
            r1      <= 1'b0;
            r2      <= 1'b0;
            busy    <= 1'b0;
            txn_cnt <= '0;
        end else if (leave) begin
            case (state)
                IDLE: begin
                    state <= REQ;
                    r1    <= 1'b1;
                    r2    <= 1'b1;
                    busy  <= 1'b1;
                end
                REQ: begin
                    state <= ACK;
                    a0    <= 1'b1;
                end
                ACK: begin
                    state <= REL;
                    r1    <= 1'b0;
                    r2    <= 1'b0;
                end
                REL: begin
                    state   <= IDLE;
                    a0      <= 1'b0;
                    busy    <= 1'b0;
                    txn_cnt <= txn_cnt + 1'b1;
                end
                default: begin
                    state <= IDLE;
                    a0    <= 1'b0;
                    r1    <= 1'b0;
                    r2    <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef SYNC_FORK_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT_CYC);

    logic [WAIT_W-1:0] wait_cnt;

    // Counter saturates at the limit so err cannot be missed by a wrap.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wait_cnt <= '0;
            err      <= 1'b0;
        end else begin
            if (wait_cnt == WAIT_MAX)
                err <= 1'b1;
            if (leave)
                wait_cnt <= '0;
            else if ((state == REQ || state == REL) && wait_cnt != WAIT_MAX)
                wait_cnt <= wait_cnt + 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fork.sv
// Directed bench for sync_fork: a cycle-level protocol model is checked every cycle, plus literal latency/count checks.
module tb_sync_fork;
    localparam int S   = 2;
    localparam int CW  = 2;
    localparam int TO  = 16;
    localparam int HN  = 16384;
    localparam int P_IDLE = 0, P_REQ = 1, P_ACK = 2, P_REL = 3;
    localparam int SEL_R1 = 0, SEL_R2 = 1, SEL_A0 = 2;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          r0 = 1'b0, a1 = 1'b0, a2 = 1'b0;
    logic          a0, r1, r2, busy, err;
    logic [CW-1:0] txn_cnt;

    int n_assert = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    sync_fork #(.SYNC_STAGES(S), .CNT_W(CW), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .reset_n(reset_n), .r0(r0), .a0(a0), .r1(r1), .a1(a1),
        .r2(r2), .a2(a2), .busy(busy), .txn_cnt(txn_cnt), .err(err)
    );

    always #5 clk = ~clk;

    // Protocol model: inputs seen by the FSM are the raw inputs S edges ago,
    // forced to 0 for anything sampled at or before the most recent reset edge.
    bit h_r0 [HN];
    bit h_a1 [HN];
    bit h_a2 [HN];
    int n_edge = 0, last_rst = -1, ph = P_IDLE, m_cnt = 0, enter = 0;
    bit m_err = 1'b0;

    function automatic bit seen(input int which, input int idx);
        if (idx < 0 || idx <= last_rst) return 1'b0;
        case (which)
            0: return h_r0[idx];
            1: return h_a1[idx];
            default: return h_a2[idx];
        endcase
    endfunction

    always @(posedge clk) begin
        bit s_r0, s_a1, s_a2;
        int prev;
        if (!reset_n) begin
            last_rst = n_edge;
            ph       = P_IDLE;
            m_cnt    = 0;
            m_err    = 1'b0;
            enter    = n_edge;
        end else begin
            s_r0 = seen(0, n_edge - S);
            s_a1 = seen(1, n_edge - S);
            s_a2 = seen(2, n_edge - S);
            prev = ph;
            case (ph)
                P_IDLE: if (s_r0) ph = P_REQ;
                P_REQ:  if (s_a1 && s_a2) ph = P_ACK;
                P_ACK:  if (!s_r0) ph = P_REL;
                default: if (!s_a1 && !s_a2) begin
                    ph = P_IDLE;
                    m_cnt = (m_cnt + 1) % (1 << CW);
                end
            endcase
`ifdef SYNC_FORK_TIMEOUT_EN
            if ((prev == P_REQ || prev == P_REL) && (n_edge - 1 - enter) >= TO) m_err = 1'b1;
`endif
            if (ph != prev) enter = n_edge;
        end
        h_r0[n_edge] = r0;
        h_a1[n_edge] = a1;
        h_a2[n_edge] = a2;
        n_edge++;
    end

    always @(negedge clk) begin
        logic [5+CW-1:0] got, want;
        if (chk_en) begin
            got  = {a0, r1, r2, busy, err, txn_cnt};
            want = {(ph == P_ACK || ph == P_REL), (ph == P_REQ || ph == P_ACK),
                    (ph == P_REQ || ph == P_ACK), (ph != P_IDLE), m_err, CW'(m_cnt)};
            n_assert++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL model_cycle edge=%0d a0,r1,r2,busy,err,cnt got=%b required=%b", n_edge, got, want);
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    function automatic logic pick(input int which);
        case (which)
            SEL_R1: return r1;
            SEL_R2: return r2;
            default: return a0;
        endcase
    endfunction

    // Counts edges until the selected output reaches val; -1 if it never does.
    task automatic wait_edges(input int which, input logic val, input int exp, input string name);
        int got = -1;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk);
            #1;
            if (pick(which) === val) begin
                got = k;
                break;
            end
        end
        check(name, got, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        r0 = 1'b0; a1 = 1'b0; a2 = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic full_cycle();
        @(negedge clk) r0 = 1'b1;
        wait_edges(SEL_R1, 1'b1, 3, "r1_rise_latency");
        check("r2_with_r1", r2, 1);
        @(negedge clk);
        @(negedge clk) begin a1 = 1'b1; a2 = 1'b1; end
        wait_edges(SEL_A0, 1'b1, 3, "a0_rise_latency");
        @(negedge clk) r0 = 1'b0;
        wait_edges(SEL_R1, 1'b0, 3, "r1_fall_latency");
        check("r2_with_r1_fall", r2, 0);
        @(negedge clk) begin a1 = 1'b0; a2 = 1'b0; end
        wait_edges(SEL_A0, 1'b0, 3, "a0_fall_latency");
    endtask

    initial begin
        int seq [5] = '{1, 2, 3, 0, 1};

        // Reset then idle
        @(posedge clk);
        #1 chk_en = 1'b1;
        @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        repeat (20) @(negedge clk);
        check("idle_outputs", {a0, r1, r2, busy, err}, 0);
        check("idle_txn_cnt", txn_cnt, 0);

        // Basic cycle
        full_cycle();
        check("basic_txn_cnt", txn_cnt, 1);

        // Skewed acks: a1 ten cycles ahead of a2
        @(negedge clk) r0 = 1'b1;
        wait_edges(SEL_R1, 1'b1, 3, "skew_r1_rise");
        @(negedge clk) a1 = 1'b1;
        repeat (10) @(negedge clk);
        check("skew_a0_held", a0, 0);
        a2 = 1'b1;
        wait_edges(SEL_A0, 1'b1, 3, "skew_a0_after_a2");
        @(negedge clk) r0 = 1'b0;
        wait_edges(SEL_R1, 1'b0, 3, "skew_r1_fall");
        @(negedge clk) begin a1 = 1'b0; a2 = 1'b0; end
        wait_edges(SEL_A0, 1'b0, 3, "skew_a0_fall");
        check("skew_txn_cnt", txn_cnt, 2);

        // Lone a2 pulse in REQ must not complete the request
        @(negedge clk) r0 = 1'b1;
        wait_edges(SEL_R1, 1'b1, 3, "pulse_r1_rise");
        @(negedge clk) a2 = 1'b1;
        @(negedge clk) a2 = 1'b0;
        repeat (8) @(negedge clk);
        check("pulse_no_a0", a0, 0);
        check("pulse_still_busy", busy, 1);
        a1 = 1'b1; a2 = 1'b1;
        wait_edges(SEL_A0, 1'b1, 3, "pulse_a0_rise");
        @(negedge clk) r0 = 1'b0;
        wait_edges(SEL_R1, 1'b0, 3, "pulse_r1_fall");
        @(negedge clk) begin a1 = 1'b0; a2 = 1'b0; end
        wait_edges(SEL_A0, 1'b0, 3, "pulse_a0_fall");
        check("pulse_txn_cnt", txn_cnt, 3);

        // Counter wrap with CNT_W=2
        do_reset();
        for (int i = 0; i < 5; i++) begin
            full_cycle();
            check($sformatf("wrap_cnt_%0d", i), txn_cnt, seq[i]);
        end

        // Reset while in ACK
        @(negedge clk) r0 = 1'b1;
        wait_edges(SEL_R1, 1'b1, 3, "midrst_r1_rise");
        @(negedge clk) begin a1 = 1'b1; a2 = 1'b1; end
        wait_edges(SEL_A0, 1'b1, 3, "midrst_a0_rise");
        @(negedge clk) begin reset_n = 1'b0; r0 = 1'b0; a1 = 1'b0; a2 = 1'b0; end
        @(posedge clk);
        #1;
        check("midrst_outputs", {a0, r1, r2, busy}, 0);
        check("midrst_txn_cnt", txn_cnt, 0);
        @(negedge clk) reset_n = 1'b1;
        full_cycle();
        check("midrst_clean_cnt", txn_cnt, 1);

        // Timeout: a2 withheld in REQ
        do_reset();
        @(negedge clk) begin r0 = 1'b1; a1 = 1'b1; end
        wait_edges(SEL_R1, 1'b1, 3, "to_r1_rise");
        repeat (24) @(negedge clk);
`ifdef SYNC_FORK_TIMEOUT_EN
        check("to_err_set", err, 1);
`else
        check("to_err_tied", err, 0);
`endif
        a2 = 1'b1;
        wait_edges(SEL_A0, 1'b1, 3, "to_a0_rise");
        @(negedge clk) r0 = 1'b0;
        wait_edges(SEL_R1, 1'b0, 3, "to_r1_fall");
        @(negedge clk) begin a1 = 1'b0; a2 = 1'b0; end
        wait_edges(SEL_A0, 1'b0, 3, "to_a0_fall");
        check("to_txn_cnt", txn_cnt, 1);
`ifdef SYNC_FORK_TIMEOUT_EN
        check("to_err_sticky", err, 1);
`else
        check("to_err_still_0", err, 0);
`endif

        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end
endmodule
